// File: rtl/mips_fetch_pkg.sv
// Shared defaults and FSM encoding for the instruction fetch stage.
package mips_fetch_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int INSTR_W_DEF   = 32;
  localparam int BUF_DEPTH_DEF = 2;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small circular skid buffer holding fetched {instr, pc} entries; head is
// presented from registered storage and reads as zero while empty.
module fetch_skid_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign do_pop     = pop && head_valid && !reset && !flush;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push    = push && !reset && !flush &&
                      ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: issues sync-read imem requests, steers the PC, and buffers returns.
// States: BOOT = idle after reset, no fetch | RUN = fetching while buffer has room.
module instruction_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int INSTR_W   = INSTR_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  instruction_address,
  output logic [ADDR_W-1:0]  next_address,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready
);

  localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic               redirect;
  logic               pop;
  logic               issue;
  logic               push;
  logic               req_valid;
  logic [ADDR_W-1:0]  req_pc;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] head;
  int                 occupancy;

  assign redirect  = jump || branch_taken;
  assign pop       = if_valid && id_ready;
  assign push      = req_valid && !redirect && !reset;
  assign imem_addr = instruction_address;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_next;
  end

  // Occupancy counts the in-flight return so the buffer can never overflow.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    occupancy  = int'(fifo_count) + int'(req_valid) - int'(pop);
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  issue = !redirect && (occupancy < BUF_DEPTH);
      default: state_next = ST_BOOT;
    endcase
  end

  always_comb begin
    next_address = instruction_address;
    if (reset)             next_address = '0;
    else if (jump)         next_address = jump_target;
    else if (branch_taken) next_address = branch_target;
    else if (issue)        next_address = instruction_address + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else if (issue) begin
      req_valid <= 1'b1;
      req_pc    <= instruction_address;
    end else begin
      req_valid <= 1'b0;
    end
  end

  fetch_skid_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (BUF_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_data  ({imem_data, req_pc}),
    .pop        (pop),
    .head_valid (if_valid),
    .head_data  (head),
    .count      (fifo_count)
  );

  assign if_instr = head[ENTRY_W-1:ADDR_W];
  assign if_pc    = head[ADDR_W-1:0];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with program-counter and imem models.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  instruction_address;
  logic [7:0]  next_address;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        jump;
  logic [7:0]  jump_target;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        id_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .instruction_address (instruction_address),
    .next_address        (next_address),
    .imem_addr           (imem_addr),
    .imem_data           (imem_data),
    .jump                (jump),
    .jump_target         (jump_target),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .if_valid            (if_valid),
    .if_instr            (if_instr),
    .if_pc               (if_pc),
    .id_ready            (id_ready)
  );

  initial begin
    instruction_address = 8'h00;
    imem_data           = 32'h0;
  end
  always @(posedge clk) instruction_address <= next_address;
  always @(posedge clk) imem_data <= 32'hA000_0000 | {24'h0, imem_addr};

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       jmp;
    logic [7:0] jt;
    logic       br;
    logic [7:0] bt;
    logic       chk;
    logic       ev;
    logic [7:0] epc;
    logic [7:0] enext;
    int         ecnt;
  } vec_t;

  vec_t vecs[41];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic jmp,
                              input logic [7:0] jt, input logic br, input logic [7:0] bt,
                              input logic chk, input logic ev, input logic [7:0] epc,
                              input logic [7:0] enext, input int ecnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.jmp = jmp; v.jt = jt; v.br = br; v.bt = bt;
    v.chk = chk; v.ev = ev; v.epc = epc; v.enext = enext; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_pc;
    reset = 1'b1; id_ready = 1'b1; jump = 1'b0; jump_target = 8'h00;
    branch_taken = 1'b0; branch_target = 8'h00;

    //             rst rdy jmp jt    br bt     chk ev epc    enext  cnt
    vecs[0]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    vecs[1]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0);
    vecs[2]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0);
    vecs[3]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h01, 0);
    vecs[4]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h02, 0);
    vecs[5]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h00, 8'h03, 1);
    vecs[6]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h01, 8'h04, 1);
    vecs[7]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h02, 8'h05, 1);
    vecs[8]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h03, 8'h05, 1);
    vecs[9]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h03, 8'h05, 2);
    vecs[10] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h03, 8'h05, 2);
    vecs[11] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h03, 8'h05, 2);
    vecs[12] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h03, 8'h05, 2);
    vecs[13] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h03, 8'h06, 2);
    vecs[14] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h04, 8'h07, 1);
    vecs[15] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h05, 8'h08, 1);
    vecs[16] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h06, 8'h08, 1);
    vecs[17] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h06, 8'h08, 2);
    vecs[18] = mk(0, 0, 1, 8'h40, 0, 8'h00, 1, 1, 8'h06, 8'h40, 2);
    vecs[19] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h41, 0);
    vecs[20] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h42, 0);
    vecs[21] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h40, 8'h43, 1);
    vecs[22] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h41, 8'h44, 1);
    vecs[23] = mk(0, 1, 1, 8'h10, 1, 8'h20, 1, 1, 8'h42, 8'h10, 1);
    vecs[24] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h11, 0);
    vecs[25] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h12, 0);
    vecs[26] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h10, 8'h13, 1);
    vecs[27] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h11, 8'h14, 1);
    vecs[28] = mk(0, 1, 0, 8'h00, 1, 8'hFE, 1, 1, 8'h12, 8'hFE, 1);
    vecs[29] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'hFF, 0);
    vecs[30] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0);
    vecs[31] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'hFE, 8'h01, 1);
    vecs[32] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'hFF, 8'h02, 1);
    vecs[33] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h00, 8'h03, 1);
    vecs[34] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h01, 8'h03, 1);
    vecs[35] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h01, 8'h03, 2);
    vecs[36] = mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h01, 8'h00, 2);
    vecs[37] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0);
    vecs[38] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h01, 0);
    vecs[39] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h02, 0);
    vecs[40] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'h00, 8'h03, 1);

    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; id_ready = vecs[i].rdy;
      jump = vecs[i].jmp; jump_target = vecs[i].jt;
      branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      #1;
      check("next_address", i, {24'h0, next_address}, {24'h0, vecs[i].enext});
      if (vecs[i].chk) begin
        check("if_valid", i, {31'h0, if_valid}, {31'h0, vecs[i].ev});
        check("count", i, 32'(dut.fifo_count), 32'(vecs[i].ecnt));
      end
      if (vecs[i].ev) begin
        check("if_pc", i, {24'h0, if_pc}, {24'h0, vecs[i].epc});
        check("if_instr", i, if_instr, 32'hA000_0000 | {24'h0, vecs[i].epc});
      end
    end

    // Reset pulse mid-stream with a request in flight: nothing stale may surface.
    @(negedge clk);
    reset = 1'b1; id_ready = 1'b1; jump = 1'b0; branch_taken = 1'b0;
    #1;
    check("rst_next_address", 0, {24'h0, next_address}, 32'h0);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      if (if_valid) begin
        lat = k;
        break;
      end
    end
    check("rst_latency", 0, 32'(lat), 32'd3);
    check("rst_first_pc", 0, {24'h0, if_pc}, 32'h0);

    // Stream with irregular stalls: every pc exactly once, in order, head stable.
    exp_pc = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      id_ready = ((c % 7) < 3) ? 1'b0 : 1'b1;
      #1;
      if (if_valid) begin
        check("stream_pc", c, {24'h0, if_pc}, 32'(exp_pc & 8'hFF));
        check("stream_instr", c, if_instr, 32'hA000_0000 | 32'(exp_pc & 8'hFF));
        if (id_ready) exp_pc++;
      end
    end
    check("stream_progress", 0, 32'(exp_pc > 12), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
